dram_responder: RTL and testbench
=================================

# dram_responder

Memory-side responder for the shared DRAM port driven by the dual-core bus arbiter. It accepts one read (`w_dram_le`) or write (`w_dram_we_t`) request at a time and answers it with a busy/idle handshake. It performs a byte, half or word access on an internal word-organised store and returns load data after a fixed, parameterised latency. It sits directly under the arbiter and acts as the simulation and FPGA-BRAM stand-in for the external DRAM controller.

## Interface
- `ADDR_W`, default 20: word-index width; the store holds 2^ADDR_W 32-bit words.
- `LATENCY`, default 4: cycles from request acceptance to `w_dram_busy` falling; must be 1..255.
- `REFRESH_PERIOD`, default 1024: cycles between refresh windows (refresh builds only).
- `REFRESH_CYCLES`, default 8: length of each refresh window (refresh builds only).

Ports:
- `CLK` in 1: single clock.
- `RST_X` in 1: reset, asynchronous, active-low.
- `w_dram_addr` in 32: byte address; bits [ADDR_W+1:2] index the word, upper bits are ignored (wrap).
- `w_dram_wdata` in 32: store data, right-aligned.
- `w_dram_ctrl` in 3: funct3 size code; 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `w_dram_le` in 1: load request level.
- `w_dram_we_t` in 1: store request level.
- `w_dram_odata` out 32: load result, extended per ctrl.
- `w_dram_busy` out 1: request in progress.
- `w_dram_err` out 1: one-cycle pulse for an illegal request.

## Operation
- Reset values: `w_dram_busy`=0, `w_dram_odata`=0, `w_dram_err`=0, state IDLE, latency counter 0, refresh counter 0.
- States: IDLE, REFWAIT, ACCESS.
- IDLE:
  - On `le|we_t`, latch addr, wdata, ctrl and kind, and set busy<=1.
  - Go to ACCESS with counter=LATENCY-1, or to REFWAIT if a refresh window is active.
- REFWAIT: hold busy; go to ACCESS when the refresh window ends.
- ACCESS:
  - Decrement the counter.
  - At 0: commit the store, or register the load result into odata; busy<=0; go to IDLE.
- `le`/`we_t` are ignored outside IDLE. The requester drops them after seeing busy=1, so one request never triggers twice.
- Store lanes come from addr[1:0]:
  - B writes one lane.
  - H writes lanes {addr[1],0}..+1.
  - W writes all four lanes.
  - Unwritten lanes keep their value.
- Load: select the lane, then sign-extend (B, H) or zero-extend (BU, HU). W returns the full word.
- Illegal requests: H/HU with addr[0]=1, W with addr[1:0]≠0, a store with ctrl≥100, ctrl 011/110/111, or `le` and `we_t` both high.
  - The request is still accepted and still takes the full LATENCY.
  - No store is performed; odata<=0.
  - `w_dram_err` pulses in the cycle busy falls.
- `w_dram_odata` holds its value until the next completed load. Stores do not change it.

## Timing
- The request is sampled at edge N. busy is high from N+1.
- busy falls at edge N+LATENCY, with odata valid in the same cycle (no refresh case).
- A new request is accepted in the first IDLE cycle after busy falls; there is no mandatory gap.
- With refresh, a request accepted during a window adds the remaining window cycles plus LATENCY.
- Reset mid-operation: the operation is abandoned and no store is committed. Outputs return to reset values immediately (asynchronous).

## Configuration
- `DRAM_RESP_REFRESH_EN` defined:
  - A free-running counter opens a refresh window of REFRESH_CYCLES every REFRESH_PERIOD cycles.
  - A request that arrives while a window is open is latched and held in REFWAIT.
  - A window that starts while the block is in ACCESS does not stall that access; the window still elapses.
- Undefined: no refresh counter, REFWAIT is unreachable, and latency is exactly LATENCY.

## Structure
- Shared package/include (define.vh) holds:
  - funct3 size constants (B/H/W/BU/HU);
  - the state encoding (IDLE/REFWAIT/ACCESS);
  - the default LATENCY and REFRESH constants.
- One sub-module, `dram_resp_mem`, holds the store:
  - synchronous-read word RAM, 2^ADDR_W × 32;
  - 4-bit byte-write-enable;
  - one read/write port.
- The top level keeps the FSM, lane/extension logic, error check and refresh counter.

## Test plan
- Store 0xDEADBEEF W at 0x100, then load W at 0x100 → busy high exactly 4 cycles each, odata=0xDEADBEEF, err=0.
- Store B 0x80 at 0x101, then load B at 0x101 → 0xFFFFFF80; LBU → 0x00000080; word 0x100 reads 0xDEAD80EF.
- Load H at 0x103 → err pulses when busy falls, odata=0, and a following load W at 0x100 returns an unchanged value.
- Hold `le` high for 3 cycles after busy rises → exactly one access is performed (busy high for 4 cycles once, not repeated).
- With `DRAM_RESP_REFRESH_EN`, REFRESH_PERIOD=16, REFRESH_CYCLES=4: issue a load on the first cycle of a window → busy high for 8 cycles, correct data.
- Deassert RST_X while in ACCESS for a store to 0x200 → busy=0 at once, and a later load at 0x200 returns the prior contents.

Source files
------------

// File: rtl/dram_responder_pkg.sv
// dram_responder_pkg
//   Shared constants and helpers for the DRAM responder.
//   - funct3 access-size codes (B/H/W/BU/HU)
//   - FSM state encoding (IDLE/REFWAIT/ACCESS)
//   - default latency and refresh timing
//   - request legality check and store byte-enable generation
package dram_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEF_LATENCY        = 4;
  localparam int DEF_REFRESH_PERIOD = 1024;
  localparam int DEF_REFRESH_CYCLES = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFWAIT = 2'd1,
    ST_ACCESS  = 2'd2
  } dram_state_e;

  // A request is illegal when both request levels are high, the size code is
  // unused, a store asks for an unsigned size, or the access is misaligned.
  function automatic logic req_illegal(
    input logic       le,
    input logic       we,
    input logic [2:0] ctrl,
    input logic [1:0] off
  );
    logic ill;
    ill = 1'b0;
    if (le && we) begin
      ill = 1'b1;
    end else begin
      case (ctrl)
        F3_B:    ill = 1'b0;
        F3_H:    ill = off[0];
        F3_W:    ill = (off != 2'b00);
        F3_BU:   ill = we;
        F3_HU:   ill = we | off[0];
        default: ill = 1'b1;
      endcase
    end
    return ill;
  endfunction

  // Byte lanes written by a (legal) store of the given size at byte offset off.
  function automatic logic [3:0] store_be(
    input logic [2:0] ctrl,
    input logic [1:0] off
  );
    logic [3:0] be;
    case (ctrl[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dram_responder_mem.sv
// dram_resp_mem
//   Word-organised backing store for the DRAM responder. One shared
//   read/write port, synchronous read (read-before-write), per-byte write
//   enables. No reset: contents survive a responder reset, like real DRAM.
// Ports:
//   CLK      in  1        clock
//   i_addr   in  ADDR_W   word index
//   i_we     in  1        write strobe
//   i_be     in  4        byte-lane enables for the write
//   i_wdata  in  32       write data, already lane-replicated
//   o_rdata  out 32       word at i_addr, registered
module dram_resp_mem #(
  parameter int ADDR_W = 20
) (
  input  logic              CLK,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_rdata;

  always_ff @(posedge CLK) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dram_responder.sv
// dram_responder
//   Memory-side responder for the shared DRAM port. Accepts one load or store
//   at a time, holds busy for LATENCY cycles (plus any refresh stall), then
//   commits the store or returns the extended load data. Illegal requests run
//   the full latency, skip the store, clear odata and pulse err.
//
// Build option:
//   DRAM_RESP_REFRESH_EN  enables the periodic refresh window; requests that
//                         arrive while a window is open wait in REFWAIT.
//
// Ports:
//   CLK           in  1   clock
//   RST_X         in  1   asynchronous active-low reset
//   w_dram_addr   in  32  byte address, [ADDR_W+1:2] selects the word
//   w_dram_wdata  in  32  store data, right-aligned
//   w_dram_ctrl   in  3   funct3 size code
//   w_dram_le     in  1   load request level
//   w_dram_we_t   in  1   store request level
//   w_dram_odata  out 32  load result
//   w_dram_busy   out 1   request in progress
//   w_dram_err    out 1   one-cycle illegal-request pulse, aligned with busy fall
//
// States:
//   ST_IDLE    | waiting for a request
//   ST_REFWAIT | request latched, stalled by an open refresh window
//   ST_ACCESS  | counting down the access latency
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int ADDR_W         = 20,
  parameter int LATENCY        = DEF_LATENCY,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [31:0] w_dram_addr,
  input  logic [31:0] w_dram_wdata,
  input  logic [2:0]  w_dram_ctrl,
  input  logic        w_dram_le,
  input  logic        w_dram_we_t,
  output logic [31:0] w_dram_odata,
  output logic        w_dram_busy,
  output logic        w_dram_err
);

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  dram_state_e       r_state;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic [2:0]        r_ctrl;
  logic              r_is_store;
  logic              r_illegal;
  logic              r_busy;
  logic [31:0]       r_odata;
  logic              r_err;

  logic              w_ref_active;
  logic              w_done;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_we;
  logic [3:0]        w_mem_be;
  logic [31:0]       w_mem_wdata;
  logic [31:0]       w_rdata;
  logic [7:0]        w_lane_b;
  logic [15:0]       w_lane_h;
  logic [31:0]       w_load_data;
  logic              w_unused_addr_hi;

  assign w_unused_addr_hi = ^w_dram_addr[31:ADDR_W+2];

`ifdef DRAM_RESP_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH_PERIOD);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_PERIOD - 1);
  localparam logic [REF_W-1:0] REF_START = REF_W'(REFRESH_PERIOD - REFRESH_CYCLES);

  logic [REF_W-1:0] r_ref_cnt;

  // Free-running; the window occupies the last REFRESH_CYCLES counts of each period.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_ref_cnt <= '0;
    end else if (r_ref_cnt == REF_LAST) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  assign w_ref_active = (r_ref_cnt >= REF_START);
`else
  localparam int UNUSED_REF_PARAMS = REFRESH_PERIOD + REFRESH_CYCLES;
  assign w_ref_active = 1'b0;
`endif

  // While idle the RAM reads the incoming address so the word is already
  // registered by the time a LATENCY=1 access completes; afterwards it keeps
  // re-reading the latched address.
  assign w_mem_addr = (r_state == ST_IDLE) ? w_dram_addr[ADDR_W+1:2] : r_addr;
  assign w_done     = (r_state == ST_ACCESS) && (r_cnt == 8'd0);
  assign w_mem_we   = w_done && r_is_store && !r_illegal;
  assign w_mem_be   = store_be(r_ctrl, r_off);

  always_comb begin
    case (r_ctrl[1:0])
      2'b00:   w_mem_wdata = {4{r_wdata[7:0]}};
      2'b01:   w_mem_wdata = {2{r_wdata[15:0]}};
      default: w_mem_wdata = r_wdata;
    endcase
  end

  dram_resp_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .CLK     (CLK),
    .i_addr  (w_mem_addr),
    .i_we    (w_mem_we),
    .i_be    (w_mem_be),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_lane_b = 8'(w_rdata >> {r_off, 3'b000});
    w_lane_h = r_off[1] ? w_rdata[31:16] : w_rdata[15:0];
    case (r_ctrl)
      F3_B:    w_load_data = {{24{w_lane_b[7]}}, w_lane_b};
      F3_H:    w_load_data = {{16{w_lane_h[15]}}, w_lane_h};
      F3_BU:   w_load_data = {24'd0, w_lane_b};
      F3_HU:   w_load_data = {16'd0, w_lane_h};
      default: w_load_data = w_rdata;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_addr     <= '0;
      r_off      <= 2'b00;
      r_wdata    <= 32'd0;
      r_ctrl     <= 3'b000;
      r_is_store <= 1'b0;
      r_illegal  <= 1'b0;
      r_busy     <= 1'b0;
      r_odata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_dram_le || w_dram_we_t) begin
            r_addr     <= w_dram_addr[ADDR_W+1:2];
            r_off      <= w_dram_addr[1:0];
            r_wdata    <= w_dram_wdata;
            r_ctrl     <= w_dram_ctrl;
            r_is_store <= w_dram_we_t && !w_dram_le;
            r_illegal  <= req_illegal(w_dram_le, w_dram_we_t, w_dram_ctrl, w_dram_addr[1:0]);
            r_busy     <= 1'b1;
            r_cnt      <= LAT_M1;
            r_state    <= w_ref_active ? ST_REFWAIT : ST_ACCESS;
          end
        end
        ST_REFWAIT: begin
          if (!w_ref_active) begin
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == 8'd0) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
            if (r_illegal) begin
              r_odata <= 32'd0;
              r_err   <= 1'b1;
            end else if (!r_is_store) begin
              r_odata <= w_load_data;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_dram_odata = r_odata;
  assign w_dram_busy  = r_busy;
  assign w_dram_err   = r_err;

endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder
//   Self-checking bench for dram_responder: directed scenarios followed by
//   randomized loads/stores, compared against a byte-array reference model.
//   Build with DRAM_RESP_REFRESH_EN to include refresh-window timing.
module tb_dram_responder;

  localparam int AW  = 4;
  localparam int LAT = 4;
  localparam int RP  = 16;
  localparam int RC  = 4;
  localparam int NBYTES = 4 << AW;
`ifdef DRAM_RESP_REFRESH_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic [31:0] w_dram_addr = '0;
  logic [31:0] w_dram_wdata = '0;
  logic [2:0]  w_dram_ctrl = '0;
  logic        w_dram_le = 1'b0;
  logic        w_dram_we_t = 1'b0;
  logic [31:0] w_dram_odata;
  logic        w_dram_busy;
  logic        w_dram_err;

  dram_responder #(
    .ADDR_W         (AW),
    .LATENCY        (LAT),
    .REFRESH_PERIOD (RP),
    .REFRESH_CYCLES (RC)
  ) dut (
    .CLK          (CLK),
    .RST_X        (RST_X),
    .w_dram_addr  (w_dram_addr),
    .w_dram_wdata (w_dram_wdata),
    .w_dram_ctrl  (w_dram_ctrl),
    .w_dram_le    (w_dram_le),
    .w_dram_we_t  (w_dram_we_t),
    .w_dram_odata (w_dram_odata),
    .w_dram_busy  (w_dram_busy),
    .w_dram_err   (w_dram_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  // edges seen since reset release, mirrors the refresh phase
  always @(posedge CLK or negedge RST_X) begin
    if (!RST_X) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [7:0]  mem_b [0:NBYTES-1];
  logic [31:0] exp_odata = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_illegal(input bit le, input bit we, input logic [2:0] ctrl,
                                       input logic [31:0] addr);
    int size;
    if (le && we) return 1'b1;
    if (ctrl == 3'd3 || ctrl == 3'd6 || ctrl == 3'd7) return 1'b1;
    if (we && ctrl[2]) return 1'b1;
    size = 1 << ctrl[1:0];
    return (addr % size) != 0;
  endfunction

  // Must be called at a negedge; returns at the negedge after busy falls.
  task automatic do_req(input bit le, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] ctrl,
                        input int hold, input string tag);
    int exp_busy, n, size, ba, ph;
    bit ill, err_early;
    logic [31:0] val;
    w_dram_le    = le;
    w_dram_we_t  = we;
    w_dram_addr  = addr;
    w_dram_wdata = wdata;
    w_dram_ctrl  = ctrl;
    exp_busy = LAT;
    if (REF_EN) begin
      ph = int'(cyc % RP);
      if (ph >= RP - RC) exp_busy += RP - ph;
    end
    ill = model_illegal(le, we, ctrl, addr);
    @(posedge CLK);
    n = 0;
    err_early = 1'b0;
    @(negedge CLK);
    while (w_dram_busy === 1'b1 && n < 400) begin
      n++;
      if (w_dram_err !== 1'b0) err_early = 1'b1;
      if (n > hold) begin
        w_dram_le   = 1'b0;
        w_dram_we_t = 1'b0;
      end
      @(negedge CLK);
    end
    w_dram_le   = 1'b0;
    w_dram_we_t = 1'b0;
    chk($sformatf("%s_busy_len", tag), n, exp_busy);
    chk($sformatf("%s_err_early", tag), {31'd0, err_early}, 32'd0);
    chk($sformatf("%s_err", tag), {31'd0, w_dram_err}, {31'd0, ill});
    size = 1 << ctrl[1:0];
    ba = int'(addr % NBYTES);
    if (ill) begin
      exp_odata = 32'd0;
    end else if (we) begin
      for (int i = 0; i < size; i++) mem_b[ba + i] = wdata[8*i +: 8];
    end else begin
      val = 32'd0;
      for (int i = 0; i < size; i++) val = val | (32'(mem_b[ba + i]) << (8 * i));
      if (!ctrl[2] && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
      if (!ctrl[2] && size == 2 && val[15]) val = val | 32'hFFFF_0000;
      exp_odata = val;
    end
    chk($sformatf("%s_odata", tag), w_dram_odata, exp_odata);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [2:0]  c;
    int k;
    bit le, we;

    repeat (3) @(negedge CLK);
    chk("rst_busy", {31'd0, w_dram_busy}, 32'd0);
    chk("rst_odata", w_dram_odata, 32'd0);
    chk("rst_err", {31'd0, w_dram_err}, 32'd0);
    #2 RST_X = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < (1 << AW); i++)
      do_req(1'b0, 1'b1, 32'(i * 4), $urandom, 3'b010, 0, "init");

    do_req(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010, 0, "sw");
    do_req(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0, "lw");
    chk("lw_const", w_dram_odata, 32'hDEAD_BEEF);
    do_req(1'b0, 1'b1, 32'h101, 32'h0000_0080, 3'b000, 0, "sb");
    do_req(1'b1, 1'b0, 32'h101, 32'h0, 3'b000, 0, "lb");
    chk("lb_const", w_dram_odata, 32'hFFFF_FF80);
    do_req(1'b1, 1'b0, 32'h101, 32'h0, 3'b100, 0, "lbu");
    chk("lbu_const", w_dram_odata, 32'h0000_0080);
    do_req(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0, "lw2");
    chk("lw2_const", w_dram_odata, 32'hDEAD_80EF);
    do_req(1'b1, 1'b0, 32'h103, 32'h0, 3'b001, 0, "lh_mis");
    chk("lh_mis_const", w_dram_odata, 32'h0);
    do_req(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0, "lw3");
    chk("lw3_const", w_dram_odata, 32'hDEAD_80EF);

    // request level held past busy rise must not retrigger
    do_req(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 3, "hold");
    @(negedge CLK);
    chk("hold_no_retrigger", {31'd0, w_dram_busy}, 32'd0);

    if (REF_EN) begin
      k = 0;
      while ((cyc % RP) != RP - RC && k < 2 * RP) begin
        @(negedge CLK);
        k++;
      end
      do_req(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0, "ref_load");
    end

    // reset in the middle of a store: abandoned, no commit
    w_dram_we_t  = 1'b1;
    w_dram_addr  = 32'h200;
    w_dram_wdata = 32'h1234_5678;
    w_dram_ctrl  = 3'b010;
    @(posedge CLK);
    @(negedge CLK);
    w_dram_we_t = 1'b0;
    @(negedge CLK);
    #2 RST_X = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, w_dram_busy}, 32'd0);
    chk("midrst_odata", w_dram_odata, 32'd0);
    chk("midrst_err", {31'd0, w_dram_err}, 32'd0);
    exp_odata = 32'd0;
    @(negedge CLK);
    #2 RST_X = 1'b1;
    @(negedge CLK);
    do_req(1'b1, 1'b0, 32'h200, 32'h0, 3'b010, 0, "midrst_load");

    for (int it = 0; it < 80; it++) begin
      k = int'($urandom_range(0, 9));
      le = (k <= 5);
      we = (k == 0) || (k >= 6);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: c = 3'b000;
          1: c = 3'b001;
          2: c = 3'b010;
          3: c = 3'b100;
          default: c = 3'b101;
        endcase
      end else begin
        c = 3'($urandom_range(0, 7));
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << c[1:0]) - 32'd1);
      d = $urandom;
      do_req(le, we, a, d, c, int'($urandom_range(0, 2)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
